// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pkg
//  Purpose  : Shared definitions for the byte-serial adder: byte width and
//             the control FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/cla_8bit.sv
`default_nettype none
// ============================================================================
//  Module   : cla_8bit
//  Purpose  : Purely combinational 8-bit carry-lookahead adder slice.
//  Ports    : a, b  (8) - addends
//             cin   (1) - carry in
//             s     (8) - sum
//             cout  (1) - carry out of bit 7
//  Revision : 1.0 - initial release
// ============================================================================
module cla_8bit
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W-1:0] w_g;
    logic [BYTE_W-1:0] w_p;
    logic [BYTE_W:0]   w_c;
    logic              w_acc;
    logic              w_prod;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is built as a flat sum of products over all lower
    // generate/propagate terms, so no carry depends on another carry.
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_prod = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            w_acc  = w_g[i];
            w_prod = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc  = w_acc | (w_prod & w_g[j]);
                w_prod = w_prod & w_p[j];
            end
            w_c[i+1] = w_acc | (w_prod & cin);
        end
    end

    assign s    = w_p ^ w_c[BYTE_W-1:0];
    assign cout = w_c[BYTE_W];

endmodule : cla_8bit
`default_nettype wire

// File: rtl/byte_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : byte_serial_adder
//  Purpose  : Multi-byte add/subtract engine that reuses one cla_8bit slice
//             over NBYTES cycles, LSB byte first, carrying between bytes.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start           - request, accepted only while ready=1
//             sub             - 0: a+b+cin, 1: a-b (cin ignored)
//             a_in, b_in (W)  - operands, captured on the accepting edge
//             cin             - add carry-in, captured on the accepting edge
//             ready           - idle, able to accept
//             busy            - byte iterations in progress
//             done            - one-cycle pulse, results valid
//             sum (W)         - result, held until the next accepted start
//             cout            - carry out of the top byte (sub: 1 = no borrow)
//             ovf             - signed overflow
//  Revision : 1.0 - initial release
// ============================================================================
module byte_serial_adder
    import adder_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int                IDX_W      = $clog2(NBYTES);
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;          // already inverted for subtraction
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_s;
    logic              w_co;
    logic              w_last;

    assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
    assign w_b_byte = r_b[r_idx*BYTE_W +: BYTE_W];
    assign w_last   = (r_idx == C_LAST_IDX);

    cla_8bit u_slice (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        // Subtraction as a + ~b + 1
                        r_b     <= sub ? ~b_in : b_in;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*BYTE_W +: BYTE_W] <= w_s;
                    r_carry                       <= w_co;
                    if (w_last) begin
                        r_cout <= w_co;
                        // Carry into the MSB recovered as a7 ^ b7 ^ s7
                        r_ovf  <= w_a_byte[BYTE_W-1] ^ w_b_byte[BYTE_W-1]
                                ^ w_s[BYTE_W-1] ^ w_co;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : byte_serial_adder
`default_nettype wire

// File: tb/tb_byte_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_serial_adder
//  Purpose  : Self-checking bench for byte_serial_adder (NBYTES=4) using a
//             result scoreboard fed by the stimulus and drained on done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_serial_adder;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         ready, busy, done, cout, ovf;
    logic [W-1:0] sum;

    byte_serial_adder #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    exp_t         q[$];
    exp_t         m_e;
    int           n_checks = 0;
    int           n_err    = 0;
    logic [W-1:0] last_sum = '0;
    logic         have_last = 1'b0;
    int           acc_cyc  = 0;
    int           first_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                m_e = q.pop_front();
                check("result_sum",  64'(sum),  64'(m_e.sum));
                check("result_cout", 64'(cout), 64'(m_e.cout));
                check("result_ovf",  64'(ovf),  64'(m_e.ovf));
                check("done_cycle",  64'(cyc),  64'(m_e.done_cyc));
                last_sum  = m_e.sum;
                have_last = 1'b1;
            end
        end
    end

    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_ready_timeout: actual=0 expected=1", tag);
        end else if (have_last) begin
            check({tag, "_sum_hold"}, 64'(sum), 64'(last_sum));
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic push, input logic [W-1:0] es,
                         input logic ec, input logic eo, input string tag);
        wait_ready(tag);
        start = 1'b1;
        sub   = s;
        a_in  = a;
        b_in  = b;
        cin   = c;
        if (push) q.push_back('{es, ec, eo, cyc + 1 + NBYTES});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    // Drop start and scramble operands: only the latched copies may matter.
    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom();
        b_in  = $urandom();
        cin   = 1'b1;
        sub   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_sum",   64'(sum),   64'd0);
        check("rst_cout",  64'(cout),  64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        rst = 1'b0;

        // Carry ripples across all bytes
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
        release_start();

        // Subtraction with and without borrow; cin ignored for sub
        issue(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        release_start();
        issue(1'b1, 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "sub_noborrow");
        release_start();

        // Signed overflow and carry-in
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        release_start();
        issue(1'b0, 32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b1, 32'h1235_5678, 1'b0, 1'b0, "add_cin");
        release_start();

        // start during RUN is ignored; ready low through RUN and DONE
        issue(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b0, "ignore");
        for (int i = 0; i <= NBYTES; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 1) begin
                start = 1'b1;
                a_in  = 32'hAAAA_AAAA;
                b_in  = 32'h5555_5555;
            end
            if (i == 2) start = 1'b0;
            check("ignore_ready_low", 64'(ready), 64'd0);
            check("ignore_busy",      64'(busy),  64'(i < NBYTES));
        end

        // Reset mid-RUN (idx=2): everything cleared, no done pulse
        issue(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "rst_run");
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_run_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_run_ready", 64'(ready), 64'd1);
        check("rst_run_busy",  64'(busy),  64'd0);
        check("rst_run_done",  64'(done),  64'd0);
        check("rst_run_sum",   64'(sum),   64'd0);
        check("rst_run_cout",  64'(cout),  64'd0);
        @(negedge clk);
        rst       = 1'b0;
        have_last = 1'b0;
        issue(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "after_rst");
        release_start();

        // Back-to-back with start held high
        issue(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b0, "b2b0");
        first_acc = acc_cyc;
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "b2b1");
        check("b2b_spacing1", 64'(acc_cyc - first_acc), 64'(NBYTES + 2));
        first_acc = acc_cyc;
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, "b2b2");
        check("b2b_spacing2", 64'(acc_cyc - first_acc), 64'(NBYTES + 2));
        release_start();

        // Drain outstanding expectations
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("pending_results", 64'(q.size()), 64'd0);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_byte_serial_adder
`default_nettype wire
